// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/MOD unit: state encoding and width defaults.
// No logic lives here.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DIV_WIDTH = 8;

  // Divide-by-zero quotient is all ones at any width; replicate this fill bit.
  localparam logic DBZ_QUOT_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// Combinational A-B as a ripple chain of full-subtractor cells; zero latency.
// No backpressure: pure combinational, borrow_out high when A < B.
module ripple_borrow_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow_out = bw[WIDTH];

endmodule

// File: rtl/restoring_divider_8bit.sv
// Restoring shift-subtract divider, one quotient bit per clock; done WIDTH+1 edges after start (1 edge on /0).
// start is only sampled in IDLE, ignored while busy or done. SIGNED_DIV_EN selects two's-complement operands.
module restoring_divider_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SIGNED_DIV_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
`endif

  logic [2*WIDTH:0] pq_sh;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t_diff;
  logic             t_borrow;

  assign pq_sh = {p_q, q_q} << 1;
  assign p_sh  = pq_sh[2*WIDTH:WIDTH];
  assign q_sh  = pq_sh[WIDTH-1:0];

  ripple_borrow_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a          (p_sh),
    .b          ({1'b0, d_q}),
    .diff       (t_diff),
    .borrow_out (t_borrow)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SIGNED_DIV_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          zero_d  = (divisor == '0);
          // A zero divisor skips the iterations but still takes the finalize cycle.
          fin_d   = (divisor == '0);
          p_d     = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef SIGNED_DIV_EN
          d_d     = divisor[WIDTH-1] ? (~divisor + ONE) : divisor;
          q_d     = (divisor == '0) ? dividend
                  : (dividend[WIDTH-1] ? (~dividend + ONE) : dividend);
          q_neg_d = (divisor != '0) && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = (divisor != '0) && dividend[WIDTH-1];
`else
          d_d     = divisor;
          q_d     = dividend;
`endif
        end
      end

      ST_RUN: begin
        if (fin_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          dbz_d   = zero_q;
          fin_d   = 1'b0;
          if (zero_q) begin
            quot_d = {WIDTH{DBZ_QUOT_FILL}};
            rem_d  = q_q;
          end else begin
`ifdef SIGNED_DIV_EN
            quot_d = q_neg_q ? (~q_q + ONE) : q_q;
            rem_d  = r_neg_q ? (~p_q[WIDTH-1:0] + ONE) : p_q[WIDTH-1:0];
`else
            quot_d = q_q;
            rem_d  = p_q[WIDTH-1:0];
`endif
          end
        end else begin
          p_d = t_borrow ? p_sh : t_diff;
          q_d = {q_sh[WIDTH-1:1], ~t_borrow};
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIGNED_DIV_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Scoreboard bench for restoring_divider_8bit: directed vectors, expected results queued at issue,
// popped and compared by a monitor on every done pulse.
module tb_restoring_divider_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  restoring_divider_8bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_seen++;
      check("done_single_pulse", int'(done_prev), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", int'(quotient), int'(mon_e.q));
        check("remainder", int'(remainder), int'(mon_e.r));
        check("div_by_zero", int'(div_by_zero), int'(mon_e.z));
      end
    end
    done_prev = (done === 1'b1);
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    @(negedge clk);
    check("idle_before_start", int'(busy), 0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    e.q = q;
    e.r = r;
    e.z = z;
    exp_q.push_back(e);
  endtask

  // Called #1 after an edge, n0 edges after the accepting edge.
  task automatic wait_done(input int n0, input int exp_lat, input bit poke);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      check("busy_running", int'(busy), 1);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, exp_lat);
    check("busy_in_done", int'(busy), 1);
    if (poke) begin
      @(negedge clk);
      dividend = 8'd7;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_cycle_start_ignored", int'(busy), 0);
    end else begin
      @(posedge clk);
      #1;
      check("busy_after_done", int'(busy), 0);
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    issue(a, b, q, r, z);
    wait_done(0, (b == '0) ? 1 : W + 1, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int seen0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;

`ifdef SIGNED_DIV_EN
    run_div(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
    run_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    run_div(8'h64, 8'hF7, 8'hF5, 8'h01, 1'b0);
    run_div(8'hF1, 8'hFC, 8'h03, 8'hFD, 1'b0);
    run_div(8'h0E, 8'hFC, 8'hFD, 8'h02, 1'b0);
    run_div(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1);
    run_div(8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1);
`else
    run_div(8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0);
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_div(8'd3, 8'd10, 8'd0, 8'd3, 1'b0);
    run_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
    run_div(8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);
    run_div(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_div(8'd128, 8'd3, 8'd42, 8'd2, 1'b0);
    run_div(8'd250, 8'd16, 8'd15, 8'd10, 1'b0);
    run_div(8'd1, 8'd1, 8'd1, 8'd0, 1'b0);
`endif

    // A second start during RUN must not disturb the running division.
    issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, W + 1, 1'b0);

    // Start pulsed only in the done cycle is dropped.
    issue(8'd12, 8'd4, 8'd3, 8'd0, 1'b0);
    wait_done(0, W + 1, 1'b1);
    seen0 = done_seen;
    repeat (15) @(posedge clk);
    #1;
    check("no_done_after_ignored_start", done_seen - seen0, 0);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    seen0 = done_seen;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_quotient", int'(quotient), 0);
    check("midreset_remainder", int'(remainder), 0);
    check("midreset_dbz", int'(div_by_zero), 0);
    repeat (15) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen - seen0, 0);
    run_div(8'd12, 8'd4, 8'd3, 8'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
